// File: rtl/pkt_head_extractor.sv
// Ingress stage ahead of the parser: passes payload beats straight through and,
// per packet, emits a tagged header capture plus initial metadata (length, port).
module pkt_head_extractor #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned HEAD_WIDTH = 512,
  parameter int unsigned META_WIDTH = 128,
  parameter int unsigned TAG_WIDTH  = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_data_valid,
  output logic                             o_data_ready,
  input  logic [DATA_WIDTH-1:0]            i_data,
  input  logic [DATA_WIDTH/8-1:0]          i_data_keep,
  input  logic                             i_data_last,
  input  logic [7:0]                       i_data_port,
  output logic                             o_pay_valid,
  input  logic                             i_pay_ready,
  output logic [DATA_WIDTH-1:0]            o_pay_data,
  output logic [DATA_WIDTH/8-1:0]          o_pay_keep,
  output logic                             o_pay_last,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0]  o_head,
  output logic [META_WIDTH+TAG_WIDTH-1:0]  o_meta
);

  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned HEAD_BEATS = HEAD_WIDTH / DATA_WIDTH;
  localparam int unsigned CNT_WIDTH  = $clog2(HEAD_BEATS + 1);
  localparam int unsigned ID_WIDTH   = TAG_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  state_t                        state_q, state_d;
  logic [CNT_WIDTH-1:0]          cnt_q, cnt_d, beats_total;
  logic [15:0]                   len_q, len_d;
  logic [7:0]                    port_q, port_d;
  logic [HEAD_WIDTH-1:0]         head_q, head_d;
  logic [ID_WIDTH-1:0]           id_q, id_d;
  logic [DATA_WIDTH-1:0]         beat_masked;
  logic [TAG_WIDTH-1:0]          tag_d;
  logic [HEAD_WIDTH+TAG_WIDTH-1:0] head_out_d;
  logic [META_WIDTH+TAG_WIDTH-1:0] meta_out_d;
  logic                          fire, last_fire, trunc;

  // Payload is a pure pass-through; the parser side never backpressures.
  assign o_pay_valid  = i_data_valid;
  assign o_data_ready = i_pay_ready;
  assign o_pay_data   = i_data;
  assign o_pay_keep   = i_data_keep;
  assign o_pay_last   = i_data_last;
  assign fire         = i_data_valid & i_pay_ready;
  assign last_fire    = fire & i_data_last;

  function automatic logic [15:0] add_sat(input logic [15:0] a, input logic [KEEP_WIDTH-1:0] k);
    logic [16:0] s;
    s = {1'b0, a};
    for (int i = 0; i < int'(KEEP_WIDTH); i++) s = s + 17'(k[i]);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    beat_masked = '0;
    for (int i = 0; i < int'(KEEP_WIDTH); i++)
      beat_masked[i*8 +: 8] = i_data_keep[i] ? i_data[i*8 +: 8] : 8'h00;
  end

  // Next-state, capture and emit computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    port_d      = port_q;
    head_d      = head_q;
    beats_total = CNT_WIDTH'(HEAD_BEATS);
    if (fire) begin
      case (state_q)
        IDLE: begin
          cnt_d       = CNT_WIDTH'(1);
          len_d       = add_sat(16'h0000, i_data_keep);
          port_d      = i_data_port;
          head_d      = '0;
          head_d[HEAD_WIDTH-1 -: DATA_WIDTH] = beat_masked;
          beats_total = CNT_WIDTH'(1);
          if (i_data_last)           state_d = IDLE;
          else if (HEAD_BEATS == 1)  state_d = BODY;
          else                       state_d = HEAD;
        end
        HEAD: begin
          for (int s = 0; s < int'(HEAD_BEATS); s++)
            if (cnt_q == CNT_WIDTH'(s)) head_d[HEAD_WIDTH-1-s*DATA_WIDTH -: DATA_WIDTH] = beat_masked;
          cnt_d       = cnt_q + CNT_WIDTH'(1);
          len_d       = add_sat(len_q, i_data_keep);
          beats_total = cnt_d;
          if (i_data_last)                            state_d = IDLE;
          else if (cnt_d == CNT_WIDTH'(HEAD_BEATS))   state_d = BODY;
        end
        BODY: begin
          len_d = add_sat(len_q, i_data_keep);
          if (i_data_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    trunc      = beats_total < CNT_WIDTH'(HEAD_BEATS);
    tag_d      = {1'b1, trunc, id_q};
    id_d       = last_fire ? id_q + ID_WIDTH'(1) : id_q;
    head_out_d = '0;
    meta_out_d = '0;
    if (last_fire) begin
      head_out_d = {tag_d, head_d};
      meta_out_d[META_WIDTH+TAG_WIDTH-1 -: TAG_WIDTH] = tag_d;
      meta_out_d[META_WIDTH-1 -: 24]                  = {len_d, port_d};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q  <= '0;
      len_q  <= '0;
      port_q <= '0;
      head_q <= '0;
      id_q   <= '0;
      o_head <= '0;
      o_meta <= '0;
    end else begin
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      port_q <= port_d;
      head_q <= head_d;
      id_q   <= id_d;
      o_head <= head_out_d;
      o_meta <= meta_out_d;
    end
  end

endmodule

// File: tb/tb_pkt_head_extractor.sv
// Randomized bench for pkt_head_extractor: a byte-level packet model predicts every
// output cycle, and directed packets pin the model with literal tag/length values.
module tb_pkt_head_extractor;

  localparam int unsigned DW = 128;
  localparam int unsigned HW = 512;
  localparam int unsigned MW = 128;
  localparam int unsigned TW = 8;
  localparam int unsigned KW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           drv_rst, drv_valid, drv_ready, drv_last;
  logic [DW-1:0]  drv_data;
  logic [KW-1:0]  drv_keep;
  logic [7:0]     drv_port;
  logic           o_data_ready, o_pay_valid, o_pay_last;
  logic [DW-1:0]  o_pay_data;
  logic [KW-1:0]  o_pay_keep;
  logic [HW+TW-1:0] o_head;
  logic [MW+TW-1:0] o_meta;

  int checks = 0;
  int failures = 0;
  int ready_mode = 0;
  bit chk_en = 0;

  pkt_head_extractor #(.DATA_WIDTH(DW), .HEAD_WIDTH(HW), .META_WIDTH(MW), .TAG_WIDTH(TW)) dut (
    .i_clk(clk), .i_rst(drv_rst), .i_data_valid(drv_valid), .o_data_ready(o_data_ready),
    .i_data(drv_data), .i_data_keep(drv_keep), .i_data_last(drv_last), .i_data_port(drv_port),
    .o_pay_valid(o_pay_valid), .i_pay_ready(drv_ready), .o_pay_data(o_pay_data),
    .o_pay_keep(o_pay_keep), .o_pay_last(o_pay_last), .o_head(o_head), .o_meta(o_meta)
  );

  task automatic check(input string name, input logic [HW+TW-1:0] act, input logic [HW+TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Byte-level reference: what the parser must see after each accepted packet.
  int               m_pos, m_beats, m_cnt, m_id;
  logic [7:0]       m_port;
  logic [HW-1:0]    m_head;
  logic             exp_valid = 1'b0;
  logic [HW+TW-1:0] exp_head;
  logic [MW+TW-1:0] exp_meta;

  always @(posedge clk) begin
    if (drv_rst) begin
      m_pos = 0; m_beats = 0; m_cnt = 0; m_id = 0; m_head = '0; exp_valid = 1'b0;
    end else begin
      exp_valid = 1'b0;
      if (drv_valid && drv_ready) begin
        if (m_beats == 0) begin m_port = drv_port; m_head = '0; end
        for (int j = 0; j < int'(KW); j++) begin
          if (drv_keep[KW-1-j]) begin
            m_cnt++;
            if (m_pos < int'(HW/8)) m_head[HW-1-8*m_pos -: 8] = drv_data[DW-1-8*j -: 8];
          end
          m_pos++;
        end
        m_beats++;
        if (drv_last) begin
          logic [TW-1:0] tag;
          tag = {1'b1, m_beats < int'(HW/DW), 6'(m_id)};
          exp_head = {tag, m_head};
          exp_meta = '0;
          exp_meta[MW+TW-1 -: TW] = tag;
          exp_meta[MW-1 -: 16]    = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
          exp_meta[MW-17 -: 8]    = m_port;
          exp_valid = 1'b1;
          m_id = (m_id + 1) % 64;
          m_pos = 0; m_beats = 0; m_cnt = 0;
        end
      end
    end
  end

  // Every cycle: emit outputs match the model, payload mirrors the inputs.
  always @(negedge clk) begin
    if (chk_en) begin
      check("head", o_head, exp_valid ? exp_head : '0);
      check("meta", (HW+TW)'(o_meta), exp_valid ? (HW+TW)'(exp_meta) : '0);
      check("payload", (HW+TW)'({o_pay_valid, o_data_ready, o_pay_data, o_pay_keep, o_pay_last}),
            (HW+TW)'({drv_valid, drv_ready, drv_data, drv_keep, drv_last}));
    end
  end

  task automatic set_ready();
    case (ready_mode)
      0:       drv_ready = 1'b1;
      1:       drv_ready = ~drv_ready;
      default: drv_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic idle(input int n);
    drv_valid = 1'b0;
    repeat (n) begin set_ready(); @(posedge clk); #1; end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input logic [7:0] p);
    bit fired;
    int tries = 0;
    drv_data = d; drv_keep = k; drv_last = l; drv_port = p; drv_valid = 1'b1;
    do begin
      set_ready();
      if (tries > 8) drv_ready = 1'b1;
      fired = drv_ready;
      @(posedge clk); #1;
      tries++;
    end while (!fired);
    drv_valid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [7:0] port, input bit rnd, input bit holes, input int gap_max);
    int nb = (len + 15) / 16;
    for (int b = 0; b < nb; b++) begin
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      for (int j = 0; j < int'(KW); j++) begin
        int idx = b * 16 + j;
        d[DW-1-8*j -: 8] = rnd ? 8'($urandom) : 8'(idx);
        k[KW-1-j] = (idx < len);
        if (holes && idx < len && $urandom_range(0, 7) == 0) k[KW-1-j] = 1'b0;
      end
      send_beat(d, k, b == nb - 1, (b == 0) ? port : 8'($urandom));
      if (b != nb - 1 && gap_max > 0) idle($urandom_range(0, gap_max));
    end
  endtask

  initial begin
    drv_rst = 1'b1; drv_valid = 1'b0; drv_ready = 1'b1; drv_last = 1'b0;
    drv_data = '0; drv_keep = '0; drv_port = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("rst_head", o_head, '0);
    check("rst_meta", (HW+TW)'(o_meta), '0);
    drv_rst = 1'b0;
    idle(2);

    // 64B packet, port 3
    send_pkt(64, 8'd3, 1'b0, 1'b0, 0);
    check("t1_tag", (HW+TW)'(o_head[HW+TW-1 -: TW]), (HW+TW)'(8'h80));
    check("t1_lenport", (HW+TW)'(o_meta[MW-1 -: 24]), (HW+TW)'({16'd64, 8'd3}));
    check("t1_byte63", (HW+TW)'(o_head[7:0]), (HW+TW)'(8'h3F));
    check("t1_byte17", (HW+TW)'(o_head[HW-1-8*17 -: 8]), (HW+TW)'(8'h11));
    idle(2);

    // 60B: tail bytes masked to zero
    send_pkt(60, 8'd7, 1'b0, 1'b0, 1);
    check("t2_tag", (HW+TW)'(o_head[HW+TW-1 -: TW]), (HW+TW)'(8'h81));
    check("t2_len", (HW+TW)'(o_meta[MW-1 -: 16]), (HW+TW)'(16'd60));
    check("t2_tail", (HW+TW)'(o_head[31:0]), '0);
    idle(1);

    // 20B: truncated, head below byte 20 zero
    send_pkt(20, 8'd9, 1'b0, 1'b0, 0);
    check("t3_tag", (HW+TW)'(o_head[HW+TW-1 -: TW]), (HW+TW)'(8'hC2));
    check("t3_len", (HW+TW)'(o_meta[MW-1 -: 16]), (HW+TW)'(16'd20));
    check("t3_low", (HW+TW)'(o_head[HW-1-160:0]), '0);
    idle(1);

    // 1500B with toggling ready
    ready_mode = 1;
    send_pkt(1500, 8'd1, 1'b1, 1'b0, 0);
    check("t4_tag", (HW+TW)'(o_head[HW+TW-1 -: TW]), (HW+TW)'(8'h83));
    check("t4_len", (HW+TW)'(o_meta[MW-1 -: 16]), (HW+TW)'(16'd1500));
    ready_mode = 0;
    idle(1);

    // Back-to-back packets, then wrap of the packet id
    send_pkt(64, 8'd4, 1'b1, 1'b0, 0);
    check("t5_tag_a", (HW+TW)'(o_head[HW+TW-1 -: TW]), (HW+TW)'(8'h84));
    send_pkt(48, 8'd5, 1'b1, 1'b0, 0);
    check("t5_tag_b", (HW+TW)'(o_head[HW+TW-1 -: TW]), (HW+TW)'(8'hC5));
    for (int p = 6; p < 64; p++) send_pkt($urandom_range(1, 80), 8'(p), 1'b1, 1'b0, 0);
    send_pkt(64, 8'd2, 1'b1, 1'b0, 0);
    check("t5_wrap", (HW+TW)'(o_head[HW+TW-1 -: TW]), (HW+TW)'(8'h80));
    idle(2);

    // Reset during beat 2 of a 4-beat packet
    send_beat({DW/8{8'hAA}}, '1, 1'b0, 8'd6);
    drv_data = {DW/8{8'hBB}}; drv_keep = '1; drv_last = 1'b0; drv_valid = 1'b1;
    drv_ready = 1'b1; drv_rst = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_head", o_head, '0);
    drv_rst = 1'b0; drv_valid = 1'b0;
    idle(2);
    send_pkt(64, 8'd8, 1'b1, 1'b0, 0);
    check("t6_tag", (HW+TW)'(o_head[HW+TW-1 -: TW]), (HW+TW)'(8'h80));
    check("t6_port", (HW+TW)'(o_meta[MW-17 -: 8]), (HW+TW)'(8'd8));
    idle(1);

    // Random traffic: lengths, keep holes, gaps, ready patterns
    for (int n = 0; n < 150; n++) begin
      ready_mode = $urandom_range(0, 2);
      send_pkt($urandom_range(1, 300), 8'($urandom), 1'b1, 1'b1, 2);
      if ($urandom_range(0, 1) != 0) idle($urandom_range(0, 2));
    end

    // Length saturation
    ready_mode = 0;
    send_pkt(70000, 8'd11, 1'b1, 1'b0, 0);
    check("sat_len", (HW+TW)'(o_meta[MW-1 -: 16]), (HW+TW)'(16'hFFFF));
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
